// File: rtl/button_conditioner_pkg.sv
// Shared types and default timing for the button/switch conditioner.
// Defaults assume a 6 MHz clock: 10 ms debounce, 500 ms hold, 100 ms repeat.
package button_conditioner_pkg;

  localparam int unsigned DEB_CYC  = 60000;
  localparam int unsigned HOLD_CYC = 3000000;
  localparam int unsigned REP_CYC  = 600000;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StRepeat
  } btn_state_e;

  // Bits needed to hold a count of 0..n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Raw inputs and conditioned outputs of the button conditioner.
interface button_conditioner_if;

  logic btn_raw;
  logic sw_raw;
  logic inc_pulse;
  logic btn_level;
  logic run_level;
  logic sw_edge;

  modport master (
    output btn_raw,
    output sw_raw,
    input  inc_pulse,
    input  btn_level,
    input  run_level,
    input  sw_edge
  );

  modport slave (
    input  btn_raw,
    input  sw_raw,
    output inc_pulse,
    output btn_level,
    output run_level,
    output sw_edge
  );

endinterface

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a debounce counter; also flags each level change.
module sync_debounce #(
  parameter int unsigned DEB_CYC = button_conditioner_pkg::DEB_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic toggle
);
  import button_conditioner_pkg::*;

  localparam int unsigned CntW = cnt_width(DEB_CYC);
  localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYC - 1);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            toggle_q;

  // The counter only runs while the synchronized sample disagrees with the level.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], raw};
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      toggle_q <= level_d ^ level_q;
    end
  end

  assign level  = level_q;
  assign toggle = toggle_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces a push-button and a run/stop switch; the button drives an
// increment strobe with press-and-hold auto-repeat.
module button_conditioner #(
  parameter int unsigned DEB_CYC  = button_conditioner_pkg::DEB_CYC,
  parameter int unsigned HOLD_CYC = button_conditioner_pkg::HOLD_CYC,
  parameter int unsigned REP_CYC  = button_conditioner_pkg::REP_CYC
) (
  input logic                 clk,
  input logic                 rst,
  button_conditioner_if.slave bus
);
  import button_conditioner_pkg::*;

  localparam int unsigned TmrCyc = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
  localparam int unsigned TmrW   = cnt_width(TmrCyc);
  // Hold phase spans HOLD_CYC-1 cycles after the press strobe; kept >= 1 so
  // the first repeat can never land right behind the press strobe.
  localparam logic [TmrW-1:0] HoldLast = TmrW'((HOLD_CYC > 2) ? HOLD_CYC - 2 : 1);
  localparam logic [TmrW-1:0] RepLast  = TmrW'(REP_CYC - 1);
  localparam logic [TmrW-1:0] TmrMax   = '1;

  logic btn_level, btn_toggle;
  logic run_level, sw_toggle;

  sync_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_btn_db (
    .clk    (clk),
    .rst    (rst),
    .raw    (bus.btn_raw),
    .level  (btn_level),
    .toggle (btn_toggle)
  );

  sync_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_sw_db (
    .clk    (clk),
    .rst    (rst),
    .raw    (bus.sw_raw),
    .level  (run_level),
    .toggle (sw_toggle)
  );

  btn_state_e      state_q, state_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic            pulse;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    pulse   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (btn_toggle && btn_level) begin
          state_d = StHold;
          tmr_d   = '0;
          pulse   = 1'b1;
        end
      end
      StHold: begin
        if (!btn_level) begin
          state_d = StIdle;
          tmr_d   = '0;
        end else if (tmr_q == HoldLast) begin
          state_d = StRepeat;
          tmr_d   = '0;
          pulse   = 1'b1;
        end else if (tmr_q != TmrMax) begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StRepeat: begin
        if (!btn_level) begin
          state_d = StIdle;
          tmr_d   = '0;
        end else if (tmr_q == RepLast) begin
          tmr_d = '0;
          pulse = 1'b1;
        end else if (tmr_q != TmrMax) begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        tmr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // The strobe is combinational, so mask it while reset is being applied.
  assign bus.inc_pulse = pulse & ~rst;
  assign bus.btn_level = btn_level;
  assign bus.run_level = run_level;
  assign bus.sw_edge   = sw_toggle;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: per-cycle check against a window-based
// behavioural model, plus literal expectations for each scenario.
module tb_button_conditioner;

  localparam int DEB    = 4;
  localparam int HOLD   = 20;
  localparam int REP    = 8;
  localparam int MaxCyc = 96;

  typedef logic [MaxCyc-1:0] vec_t;

  logic clk = 1'b0;
  logic rst;
  button_conditioner_if bus ();

  button_conditioner #(
    .DEB_CYC  (DEB),
    .HOLD_CYC (HOLD),
    .REP_CYC  (REP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  vec_t  st_btn, st_sw, st_rst;
  vec_t  ex_pulse, ex_blev, ex_run, ex_edge;
  vec_t  ob_pulse, ob_blev, ob_run, ob_edge;
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  bit    checking = 1'b0;
  string test_name = "none";

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s [%s] cyc=%0d got=%b want=%b", name, test_name, cyc, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input vec_t act, input vec_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s [%s] got=%h want=%h", name, test_name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic raw_at(input vec_t v, input int c);
    if (c < 0 || c >= MaxCyc) return 1'b0;
    return v[c];
  endfunction

  // Everything before cycle 0 is treated as held in reset.
  function automatic logic rst_at(input int c);
    if (c < 0) return 1'b1;
    if (c >= MaxCyc) return 1'b0;
    return st_rst[c];
  endfunction

  // Raw value seen by the debouncer at clock edge e (three edges after it was driven).
  function automatic logic samp(input vec_t v, input int e);
    if (rst_at(e - 3) || rst_at(e - 2)) return 1'b0;
    return raw_at(v, e - 3);
  endfunction

  // Level flips at edge e when the last DEB samples, all since the last change, disagree.
  function automatic logic settles(input vec_t v, input int e, input logic lvl, input int last);
    if (e - DEB + 1 <= last) return 1'b0;
    for (int k = e - DEB + 1; k <= e; k++) begin
      if (samp(v, k) == lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic build_model(input int n);
    logic bl, rl, bl_prev, rl_prev;
    int   bl_last, rl_last, press, d;
    bl = 1'b0; rl = 1'b0; bl_last = 0; rl_last = 0; press = -1;
    ex_pulse = '0; ex_blev = '0; ex_run = '0; ex_edge = '0;
    for (int t = 0; t < n; t++) begin
      bl_prev = bl;
      rl_prev = rl;
      if (rst_at(t - 1)) begin
        bl = 1'b0; rl = 1'b0; bl_last = t; rl_last = t; press = -1;
      end else begin
        if (settles(st_btn, t, bl, bl_last)) begin bl = ~bl; bl_last = t; end
        if (settles(st_sw, t, rl, rl_last)) begin rl = ~rl; rl_last = t; end
      end
      if (!bl) press = -1;
      else if (!bl_prev) press = t;
      ex_blev[t] = bl;
      ex_run[t]  = rl;
      ex_edge[t] = !rst_at(t - 1) && (rl != rl_prev);
      if (press >= 0 && !rst_at(t)) begin
        d = t - press;
        ex_pulse[t] = (d == 0) || (d == HOLD - 1) ||
                      (d > HOLD - 1 && ((d - (HOLD - 1)) % REP) == 0);
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic vec_t span(input int lo, input int hi);
    vec_t v;
    v = '0;
    for (int i = lo; i <= hi; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic vec_t at(input int i);
    vec_t v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic clear_stim();
    st_btn = '0; st_sw = '0; st_rst = '0;
    ob_pulse = '0; ob_blev = '0; ob_run = '0; ob_edge = '0;
  endtask

  // Reset covers cycles -2 and -1; cycle t is the interval after clock edge t.
  task automatic run(input int n);
    build_model(n);
    checking = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; bus.btn_raw = 1'b0; bus.sw_raw = 1'b0;
    @(posedge clk); #1;
    for (int t = 0; t < n; t++) begin
      @(posedge clk); #1;
      cyc = t;
      rst = st_rst[t];
      bus.btn_raw = st_btn[t];
      bus.sw_raw = st_sw[t];
      checking = 1'b1;
    end
    @(negedge clk); #1;
    checking = 1'b0;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (checking) begin
      check_bit("inc_pulse", bus.inc_pulse, ex_pulse[cyc]);
      check_bit("btn_level", bus.btn_level, ex_blev[cyc]);
      check_bit("run_level", bus.run_level, ex_run[cyc]);
      check_bit("sw_edge", bus.sw_edge, ex_edge[cyc]);
      ob_pulse[cyc] = bus.inc_pulse;
      ob_blev[cyc]  = bus.btn_level;
      ob_run[cyc]   = bus.run_level;
      ob_edge[cyc]  = bus.sw_edge;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog [%s] cyc=%0d got=running want=finished", test_name, cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t zero, lit;
    zero = '0;
    rst = 1'b1;
    bus.btn_raw = 1'b0;
    bus.sw_raw = 1'b0;

    // Bouncing button: 2-cycle glitches never qualify.
    test_name = "glitch";
    clear_stim();
    for (int t = 0; t < 30; t++) st_btn[t] = ((t / 2) % 2) == 0;
    run(50);
    check_vec("btn_level quiet", ob_blev, zero);
    check_vec("inc_pulse quiet", ob_pulse, zero);
    check_vec("model inc_pulse quiet", ex_pulse, zero);
    check_vec("run_level reset", ob_run, zero);

    // Short press, cycles 0..10.
    test_name = "short_press";
    clear_stim();
    st_btn = span(0, 10);
    run(40);
    lit = span(6, 16);
    check_vec("btn_level window", ob_blev, lit);
    lit = at(6);
    check_vec("single pulse", ob_pulse, lit);
    check_vec("model single pulse", ex_pulse, lit);

    // Long press, cycles 0..59; release reaches btn_level at 66.
    test_name = "long_press";
    clear_stim();
    st_btn = span(0, 59);
    run(80);
    lit = at(6) | at(25) | at(33) | at(41) | at(49) | at(57) | at(65);
    check_vec("repeat pulses", ob_pulse, lit);
    check_vec("model repeat pulses", ex_pulse, lit);
    lit = span(6, 65);
    check_vec("btn_level held", ob_blev, lit);

    // Run/stop switch on at 0, off at 20.
    test_name = "switch";
    clear_stim();
    st_sw = span(0, 19);
    run(40);
    lit = span(6, 25);
    check_vec("run_level window", ob_run, lit);
    lit = at(6) | at(26);
    check_vec("sw_edge strobes", ob_edge, lit);
    check_vec("model sw_edge strobes", ex_edge, lit);
    check_vec("no button pulse", ob_pulse, zero);

    // Reset in the repeat phase with the button still held.
    test_name = "reset_mid_repeat";
    clear_stim();
    st_btn = span(0, 59);
    st_rst = at(30);
    run(60);
    lit = at(6) | at(25) | at(37) | at(56);
    check_vec("pulses across reset", ob_pulse, lit);
    check_vec("model pulses across reset", ex_pulse, lit);
    lit = span(6, 30) | span(37, 59);
    check_vec("btn_level across reset", ob_blev, lit);

    // Button and switch stepping together.
    test_name = "simultaneous";
    clear_stim();
    st_btn = span(0, 14);
    st_sw = span(0, 14);
    run(30);
    lit = at(6);
    check_vec("button pulse", ob_pulse, lit);
    lit = at(6) | at(21);
    check_vec("switch edges", ob_edge, lit);
    lit = span(6, 20);
    check_vec("run_level window", ob_run, lit);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
